mpadder: RTL and testbench

MPADDER -- requirements
Module: mpadder

---
 rtl/mpadder_pkg.sv | 38 +++
 rtl/mpadder_csa_514.sv | 23 ++
 rtl/mpadder.sv | 95 +++++++++
 tb/tb_mpadder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpadder_pkg.sv
// ============================================================================
// Module      : mpadder_pkg
// Description : Shared width, debug-select encodings and operation decode for
//               the 514-bit carry-save accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpadder_pkg;

  localparam int ADDER_WIDTH = 514;

  localparam logic [3:0] SEL_SUM   = 4'd0;
  localparam logic [3:0] SEL_CARRY = 4'd1;
  localparam logic [3:0] SEL_VALUE = 4'd8;

  typedef enum logic [1:0] {
    OP_RESOLVE   = 2'd0,
    OP_ADD       = 2'd1,
    OP_ADD_SHIFT = 2'd2,
    OP_SUB       = 2'd3
  } op_e;

  // Subtract takes priority over shift; both only matter on accumulate cycles.
  function automatic op_e decode_op(input logic en, input logic sub, input logic sh);
    if (!en)
      return OP_RESOLVE;
    else if (sub)
      return OP_SUB;
    else if (sh)
      return OP_ADD_SHIFT;
    else
      return OP_ADD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpadder_csa_514.sv
// ============================================================================
// Module      : csa_514
// Description : Bitwise 3:2 compressor; carry output is left unshifted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_514
  import mpadder_pkg::*;
(
  input  logic [ADDER_WIDTH-1:0] x,
  input  logic [ADDER_WIDTH-1:0] y,
  input  logic [ADDER_WIDTH-1:0] z,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic [ADDER_WIDTH-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

`default_nettype wire

// File: rtl/mpadder.sv
// ============================================================================
// Module      : mpadder
// Description : 514-bit carry-save add/subtract/halve accumulator with
//               carry-resolution cycles. Macro MPADDER_DEBUG_EN enables the
//               S/C/V debug view select; otherwise debugResult is always V.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpadder
  import mpadder_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADDER_WIDTH-1:0] in_a,
  input  logic                   subtract,
  input  logic                   shift,
  input  logic                   enableC,
  input  logic [3:0]             showFluffyPonies,
  output logic [ADDER_WIDTH-1:0] debugResult,
  output logic                   cZero
);

  logic [ADDER_WIDTH-1:0] r_sum;
  logic [ADDER_WIDTH-1:0] r_carry;

  op_e                    w_op;
  logic [ADDER_WIDTH-1:0] w_z;
  logic                   w_cin;
  logic [ADDER_WIDTH-1:0] w_s;
  logic [ADDER_WIDTH-1:0] w_maj;
  logic [ADDER_WIDTH-1:0] w_c_next;
  logic [ADDER_WIDTH-1:0] w_value;

  assign w_op = decode_op(enableC, subtract, shift);

  // A resolution cycle is the same compressor with a zero third operand.
  always_comb begin
    w_z   = in_a;
    w_cin = 1'b0;
    case (w_op)
      OP_SUB: begin
        w_z   = ~in_a;
        w_cin = 1'b1;
      end
      OP_RESOLVE: w_z = '0;
      default: ;
    endcase
  end

  csa_514 u_csa (
    .x     (r_sum),
    .y     (r_carry),
    .z     (w_z),
    .sum   (w_s),
    .carry (w_maj)
  );

  assign w_c_next = {w_maj[ADDER_WIDTH-2:0], w_cin};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_sum   <= '0;
      r_carry <= '0;
    end else if (w_op == OP_ADD_SHIFT) begin
      r_sum   <= w_s >> 1;
      r_carry <= w_c_next >> 1;
    end else begin
      r_sum   <= w_s;
      r_carry <= w_c_next;
    end
  end

  assign w_value = r_sum + r_carry;
  assign cZero   = (r_carry == '0);

`ifdef MPADDER_DEBUG_EN
  always_comb begin
    debugResult = '0;
    case (showFluffyPonies)
      SEL_SUM:   debugResult = r_sum;
      SEL_CARRY: debugResult = r_carry;
      SEL_VALUE: debugResult = w_value;
      default:   debugResult = '0;
    endcase
  end
`else
  logic w_unused_sel;
  assign w_unused_sel = |showFluffyPonies;
  assign debugResult  = w_value;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mpadder.sv
// ============================================================================
// Module      : tb_mpadder
// Description : Scoreboard bench for mpadder against a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpadder;
  import mpadder_pkg::*;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [ADDER_WIDTH-1:0] in_a;
  logic                   subtract;
  logic                   shift;
  logic                   enableC;
  logic [3:0]             showFluffyPonies;
  logic [ADDER_WIDTH-1:0] debugResult;
  logic                   cZero;

  always #5 clk = ~clk;

  mpadder dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_a             (in_a),
    .subtract         (subtract),
    .shift            (shift),
    .enableC          (enableC),
    .showFluffyPonies (showFluffyPonies),
    .debugResult      (debugResult),
    .cZero            (cZero)
  );

  typedef struct {
    logic [ADDER_WIDTH-1:0] v;
    string                  name;
  } exp_t;

  exp_t                   q[$];
  logic [ADDER_WIDTH-1:0] mv;
  int                     n_checks = 0;
  int                     n_fail   = 0;

  task automatic check(input string nm, input logic [ADDER_WIDTH-1:0] act,
                       input logic [ADDER_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: the value after each capturing edge is compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, debugResult, e.v);
    end
  end

  function automatic logic [ADDER_WIDTH-1:0] rnd();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[ADDER_WIDTH-1:0];
  endfunction

  function automatic logic [3:0] value_sel();
`ifdef MPADDER_DEBUG_EN
    return SEL_VALUE;
`else
    return 4'($urandom_range(0, 15));
`endif
  endfunction

  task automatic op(input bit en, input bit sub, input bit sh,
                    input logic [ADDER_WIDTH-1:0] a, input string nm);
    logic [ADDER_WIDTH-1:0] t;
    enableC          = en;
    subtract         = sub;
    shift            = sh;
    in_a             = a;
    showFluffyPonies = value_sel();
    if (en) begin
      if (sub) mv = mv - a;
      else if (sh) begin
        t  = mv + a;
        mv = t >> 1;
      end else mv = mv + a;
    end
    @(posedge clk);
    q.push_back('{mv, nm});
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    drain();
    resetn = 1'b1;
    #2;
    check({nm, "_czero"}, {{(ADDER_WIDTH-1){1'b0}}, cZero}, 1);
    for (int s = 0; s < 4; s++) begin
      logic [3:0] sels [4] = '{SEL_SUM, SEL_CARRY, SEL_VALUE, 4'd5};
      showFluffyPonies = sels[s];
      #1;
      check($sformatf("%s_dbg_sel%0d", nm, sels[s]), debugResult, '0);
    end
    mv = '0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
  endtask

  logic [ADDER_WIDTH-1:0] n_val;
  logic [ADDER_WIDTH-1:0] exp_m;
  logic [ADDER_WIDTH-1:0] mask505;
  bit                     resolved;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1; in_a = '0; subtract = 0; shift = 0; enableC = 0;
    showFluffyPonies = SEL_VALUE;
    mv = '0;
    repeat (2) @(posedge clk);
    do_reset("init_reset");

    // Add
    op(1, 0, 0, 514'd3, "add3a");
    op(1, 0, 0, 514'd3, "add3b");
    op(1, 0, 0, 514'd0, "add0");
    drain();
    showFluffyPonies = SEL_VALUE; #1;
    check("add_total_6", debugResult, 514'd6);

    // Montgomery-style sequence; top bits clear so no intermediate wrap occurs
    do_reset("mont_reset");
    n_val = rnd();
    n_val[513:512] = 2'b00;
    n_val[511] = 1'b1;
    n_val[0]   = 1'b1;
    op(1, 0, 0, 514'd3, "m_add3a");
    op(1, 0, 0, 514'd3, "m_add3b");
    op(1, 0, 0, 514'd0, "m_add0");
    repeat (3) op(1, 0, 0, n_val, "m_addN");
    op(1, 0, 1, 514'd1, "m_shift1");
    drain();
    exp_m = (n_val * 3 + 7) >> 1;
    showFluffyPonies = SEL_VALUE; #1;
    check("mont_result", debugResult, exp_m);

    // Carry resolution
    resolved = 0;
    for (int i = 0; i < 514 && !resolved; i++) begin
      op(0, $urandom_range(0, 1), $urandom_range(0, 1), rnd(), "resolve_hold");
      drain();
      resolved = cZero;
    end
    check("resolve_czero", {{(ADDER_WIDTH-1){1'b0}}, cZero}, 1);
    showFluffyPonies = SEL_VALUE; #1;
    check("resolve_value", debugResult, exp_m);
`ifdef MPADDER_DEBUG_EN
    showFluffyPonies = SEL_SUM; #1;
    check("resolve_sum_eq_v", debugResult, exp_m);
    showFluffyPonies = SEL_CARRY; #1;
    check("resolve_carry_zero", debugResult, '0);
    showFluffyPonies = 4'd15; #1;
    check("resolve_other_sel", debugResult, '0);
`else
    showFluffyPonies = 4'd3; #1;
    check("nodebug_sel_ignored", debugResult, exp_m);
`endif
    op(0, 0, 0, '0, "resolve_steady");
    drain();

    // Subtract
    do_reset("sub_reset");
    op(1, 0, 0, 514'd10, "s_add10");
    op(1, 1, 1, 514'd3, "s_sub3");
    drain();
    showFluffyPonies = SEL_VALUE; #1;
    check("sub_7", debugResult, 514'd7);
    op(1, 1, 0, 514'd8, "s_sub8");
    drain();
    showFluffyPonies = SEL_VALUE; #1;
    check("sub_underflow", debugResult, {ADDER_WIDTH{1'b1}});

    // Wrap
    do_reset("wrap_reset");
    op(1, 0, 0, {ADDER_WIDTH{1'b1}}, "w_addmax");
    op(1, 0, 0, 514'd1, "w_add1");
    drain();
    showFluffyPonies = SEL_VALUE; #1;
    check("wrap_zero", debugResult, '0);

    // Random add/subtract/resolve, no halving (pure modular arithmetic)
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 3);
      case (k)
        0: op(1, 0, 0, rnd(), "rnd_add");
        1: op(1, 1, $urandom_range(0, 1), rnd(), "rnd_sub");
        default: op(0, $urandom_range(0, 1), $urandom_range(0, 1), rnd(), "rnd_resolve");
      endcase
    end

    // Mid-stream reset discards state
    do_reset("mid_reset");
    op(1, 0, 0, 514'd5, "post_reset_add5");
    drain();
    showFluffyPonies = SEL_VALUE; #1;
    check("post_reset_5", debugResult, 514'd5);

    // Random halving phase with bounded magnitudes so no wrap ever occurs
    do_reset("half_reset");
    mask505 = '0;
    mask505[504:0] = '1;
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 2);
      case (k)
        0: op(1, 0, 0, rnd() & mask505, "half_add");
        1: op(1, 0, 1, rnd() & mask505, "half_shift");
        default: op(0, 0, 0, rnd(), "half_resolve");
      endcase
    end
    drain();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
